somador_cla_pipe: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor: WIDTH-bit operands split into

---
 rtl/somador_cla_pipe_if.sv | 28 ++
 rtl/somador_cla_pipe.sv | 124 ++++++++++++
 tb/tb_somador_cla_pipe.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/somador_cla_pipe_if.sv
// Operand/result bundle for the pipelined CLA adder/subtractor.
// Handshake: a beat moves across a side on a rising clock edge where valid & ready are both 1;
// valid and payload hold until that edge, and ready may depend combinationally on the far side.
interface somador_cla_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, Cout, Ovf
    );
endinterface

// File: rtl/somador_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one GRUPO-bit group resolved per stage.
// Optional feature macro SOMADOR_SAT_EN: signed saturation of S at the output stage.
module somador_cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GRUPO = 4
) (
    input logic              clk,
    input logic              rst,
    somador_cla_pipe_if.slave bus
);
    // WIDTH is expected to be a whole multiple of GRUPO.
    localparam int NSTG = WIDTH / GRUPO;

    logic adv;

    // Stage registers: operands (B already conditioned for sub), partial sum, carry, valid.
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             c_q [NSTG];
    logic             v_q [NSTG];
    logic             ovf_q;

    logic [WIDTH-1:0] a_in [NSTG];
    logic [WIDTH-1:0] b_in [NSTG];
    logic [WIDTH-1:0] s_in [NSTG];
    logic             c_in [NSTG];
    logic             v_in [NSTG];

    logic [WIDTH-1:0] s_nx [NSTG];
    logic             c_nx [NSTG];
    logic             ovf_nx;
    logic [WIDTH-1:0] s_last;

    logic g;
    logic p;
    logic cc;
    logic c_msb;

    assign adv          = ~v_q[NSTG-1] | bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = v_q[NSTG-1];
    assign bus.S        = s_q[NSTG-1];
    assign bus.Cout     = c_q[NSTG-1];
    assign bus.Ovf      = ovf_q;

    // Stage inputs: stage 0 sees the port beat, stage k sees the register of stage k-1.
    always_comb begin
        a_in[0] = bus.A;
        b_in[0] = bus.sub ? ~bus.B : bus.B;
        s_in[0] = '0;
        c_in[0] = bus.sub | bus.Cin;
        v_in[0] = bus.in_valid;
        for (int k = 1; k < NSTG; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
    end

    // Per-group generate/propagate lookahead; each stage fills in its own slice of the sum.
    always_comb begin
        g      = 1'b0;
        p      = 1'b0;
        cc     = 1'b0;
        c_msb  = 1'b0;
        ovf_nx = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            s_nx[k] = s_in[k];
            cc      = c_in[k];
            for (int i = 0; i < GRUPO; i++) begin
                g = a_in[k][k*GRUPO+i] & b_in[k][k*GRUPO+i];
                p = a_in[k][k*GRUPO+i] | b_in[k][k*GRUPO+i];
                s_nx[k][k*GRUPO+i] = a_in[k][k*GRUPO+i] ^ b_in[k][k*GRUPO+i] ^ cc;
                c_msb = cc;
                cc    = g | (p & cc);
            end
            c_nx[k] = cc;
            if (k == NSTG - 1) begin
                ovf_nx = c_msb ^ cc;
            end
        end
    end

    // Output stage value; saturation folds in here so it costs no extra cycle.
    always_comb begin
        s_last = s_nx[NSTG-1];
`ifdef SOMADOR_SAT_EN
        if (ovf_nx) begin
            s_last = s_nx[NSTG-1][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                           : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // Everything advances together; a stalled output freezes the whole pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                c_q[k] <= c_nx[k];
                v_q[k] <= v_in[k];
                if (k == NSTG - 1) begin
                    s_q[k] <= s_last;
                end else begin
                    s_q[k] <= s_nx[k];
                end
            end
            ovf_q <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_somador_cla_pipe.sv
// Self-checking bench for somador_cla_pipe (WIDTH=16, GRUPO=4): directed vectors, stall,
// reset with beats in flight, and a randomized stream against an integer reference model.
`timescale 1ns/1ps
module tb_somador_cla_pipe;
    localparam int WIDTH = 16;
    localparam int GRUPO = 4;
    localparam int NSTG  = WIDTH / GRUPO;
    localparam int RW    = WIDTH + 2;
    localparam int NRAND = 10000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Packed result {Ovf, Cout, S}.
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] got_q [$];

    somador_cla_pipe_if #(.WIDTH(WIDTH)) bus ();

    somador_cla_pipe #(.WIDTH(WIDTH), .GRUPO(GRUPO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sb);
        int ua, ub, sa, sbv, ures, sres;
        logic [WIDTH-1:0] s;
        logic cout, ovf;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            ures = ua - ub;
            sres = sa - sbv;
            cout = (ua >= ub);
        end else begin
            ures = ua + ub + int'(cin);
            sres = sa + sbv + int'(cin);
            cout = (ures >= (1 << WIDTH));
        end
        ovf = (sres > ((1 << (WIDTH-1)) - 1)) || (sres < -(1 << (WIDTH-1)));
        s   = ures[WIDTH-1:0];
`ifdef SOMADOR_SAT_EN
        if (ovf) s = (sres > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
        return {ovf, cout, s};
    endfunction

    // Driver: apply inputs just after the falling edge, then record what the coming edge transfers.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sb, input logic ordy, output logic acc);
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.Cin       = cin;
        bus.sub       = sb;
        bus.out_ready = ordy;
        #1;
        acc = iv && bus.in_ready;
        if (acc) exp_q.push_back(model(a, b, cin, sb));
        if (bus.out_valid && ordy) got_q.push_back({bus.Ovf, bus.Cout, bus.S});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        drive(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
        tick();
    endtask

    task automatic test_reset();
        logic acc;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.S !== 16'h0000) begin errors++; $display("FAIL reset_S got %h want 0000", bus.S); end
        checks++;
        if (bus.Cout !== 1'b0 || bus.Ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got Cout=%b Ovf=%b want 0 0", bus.Cout, bus.Ovf);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tick();
    endtask

    logic [WIDTH-1:0] va [4] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005};
    logic [WIDTH-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007};
    logic             vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic             vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef SOMADOR_SAT_EN
    logic [RW-1:0]    vw [4] = '{{2'b00, 16'h0100}, {2'b01, 16'h0000}, {2'b10, 16'h7FFF}, {2'b00, 16'hFFFE}};
`else
    logic [RW-1:0]    vw [4] = '{{2'b00, 16'h0100}, {2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b00, 16'hFFFE}};
`endif

    task automatic test_vectors();
        logic acc;
        int lat;
        for (int n = 0; n < 4; n++) begin
            exp_q.delete();
            got_q.delete();
            drive(1'b1, va[n], vb[n], vc[n], vs[n], 1'b1, acc);
            tick();
            lat = 1;
            while (!bus.out_valid && lat < 20) begin
                idle(1'b1);
                lat++;
            end
            checks++;
            if (lat !== NSTG) begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", n, lat, NSTG); end
            idle(1'b1);
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL vec%0d_count got %0d want 1", n, got_q.size());
            end else if (got_q[0] !== vw[n]) begin
                errors++; $display("FAIL vec%0d_result got %h want %h", n, got_q[0], vw[n]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] sa [8];
        logic [WIDTH-1:0] sbb [8];
        logic sc [8];
        logic ss [8];
        logic [RW-1:0] held;
        logic acc, ordy;
        int sent;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            sa[i]  = WIDTH'($urandom);
            sbb[i] = WIDTH'($urandom);
            sc[i]  = 1'($urandom_range(0, 1));
            ss[i]  = 1'($urandom_range(0, 1));
        end
        sent = 0;
        held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ordy = !(cyc >= 6 && cyc < 9);
            if (sent < 8) drive(1'b1, sa[sent], sbb[sent], sc[sent], ss[sent], ordy, acc);
            else drive(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
            if (acc) sent++;
            if (!ordy) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    errors++; $display("FAIL stall_ready got in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
                end
                if (cyc == 6) held = {bus.Ovf, bus.Cout, bus.S};
                else begin
                    checks++;
                    if ({bus.Ovf, bus.Cout, bus.S} !== held) begin
                        errors++; $display("FAIL stall_hold got %h want %h", {bus.Ovf, bus.Cout, bus.S}, held);
                    end
                end
            end
            tick();
        end
        checks++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++; $display("FAIL stall_count got %0d want 8 (accepted %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stall_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_inflight();
        logic acc;
        int lat;
        exp_q.delete();
        got_q.delete();
        drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, acc); tick();
        drive(1'b1, 16'h4321, 16'h0101, 1'b1, 1'b0, 1'b0, acc); tick();
        drive(1'b1, 16'h0F0F, 16'h0303, 1'b0, 1'b1, 1'b0, acc); tick();
        idle(1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL inflight_pre got out_valid=%b want 1", bus.out_valid); end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.S !== 16'h0000) begin
            errors++; $display("FAIL inflight_reset got out_valid=%b S=%h want 0 0000", bus.out_valid, bus.S);
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        repeat (10) idle(1'b1);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL inflight_stale got %0d results want 0", got_q.size()); end
        drive(1'b1, 16'hABCD, 16'h1357, 1'b1, 1'b0, 1'b1, acc);
        tick();
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            idle(1'b1);
            lat++;
        end
        checks++;
        if (lat !== NSTG) begin errors++; $display("FAIL inflight_latency got %0d want %0d", lat, NSTG); end
        idle(1'b1);
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            errors++; $display("FAIL inflight_new_count got %0d want 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL inflight_new got %h want %h", got_q[0], exp_q[0]);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic acc, iv, ordy, hold_prev;
        logic [RW-1:0] held;
        int sent, cyc, shown;
        exp_q.delete();
        got_q.delete();
        sent = 0;
        cyc = 0;
        hold_prev = 1'b0;
        held = '0;
        while ((sent < NRAND || got_q.size() < exp_q.size()) && cyc < 60000) begin
            iv   = (sent < NRAND) && ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            if (hold_prev) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.Ovf, bus.Cout, bus.S} !== held) begin
                    errors++; $display("FAIL random_hold got v=%b %h want 1 %h", bus.out_valid, {bus.Ovf, bus.Cout, bus.S}, held);
                end
            end
            drive(iv, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ordy, acc);
            checks++;
            if (bus.in_ready !== (!bus.out_valid || ordy)) begin
                errors++; $display("FAIL random_in_ready got %b out_valid=%b out_ready=%b", bus.in_ready, bus.out_valid, ordy);
            end
            if (acc) sent++;
            hold_prev = bus.out_valid && !ordy;
            held = {bus.Ovf, bus.Cout, bus.S};
            tick();
            cyc++;
        end
        checks++;
        if (sent != NRAND || got_q.size() != NRAND) begin
            errors++; $display("FAIL random_count got sent=%0d out=%0d want %0d", sent, got_q.size(), NRAND);
        end
        shown = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                if (shown < 10) $display("FAIL random_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
                shown++;
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end
endmodule
